// File: rtl/mem_phase_ctrl_if.sv
// Memory-side request/acknowledge bus between the phase sequencer and the
// memory interface.
interface mem_phase_ctrl_if #(
   parameter int ADDR_W = 27,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W/8-1:0] mem_be;
   logic                mem_rreq;
   logic                mem_wreq;
   logic [DATA_W-1:0]   mem_rdata;
   logic                mem_ack;

   modport master (
      output mem_addr, mem_wdata, mem_be, mem_rreq, mem_wreq,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_addr, mem_wdata, mem_be, mem_rreq, mem_wreq,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/mem_phase_ctrl.sv
// Fetch/execute phase sequencer: generates the E phase and commit strobe and
// runs instruction/data accesses over a req/ack memory port with a timeout.
module mem_phase_ctrl #(
   parameter int ADDR_W  = 27,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ena,
   input  logic                jisr,
   input  logic [ADDR_W-1:0]   pc_word,
   input  logic [ADDR_W-1:0]   data_addr,
   input  logic [DATA_W-1:0]   data_wdata,
   input  logic [DATA_W/8-1:0] data_be,
   input  logic                rren,
   input  logic                wren,
   output logic [DATA_W-1:0]   instr,
   output logic [DATA_W-1:0]   load_data,
   output logic                E,
   output logic                commit,
   output logic                abort,
   output logic                busy,
   mem_phase_ctrl_if.master    mem
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_DATA,
      S_COMMIT,
      S_ABORT
   } state_t;

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [DATA_W-1:0]  instr_reg, load_reg;
   logic               instr_cap, load_cap;
   logic               timed_out;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         instr_reg <= '0;
         load_reg  <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (instr_cap)
            instr_reg <= mem.mem_rdata;
         if (load_cap)
            load_reg <= mem.mem_rdata;
      end
   end

   // The last allowed wait cycle still accepts an ack; only a miss there aborts.
   assign timed_out = (cnt_reg == CNT_W'(TIMEOUT - 1)) && !mem.mem_ack;

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      instr_cap      = 1'b0;
      load_cap       = 1'b0;
      E              = 1'b0;
      commit         = 1'b0;
      abort          = 1'b0;
      mem.mem_addr   = '0;
      mem.mem_wdata  = '0;
      mem.mem_be     = '0;
      mem.mem_rreq   = 1'b0;
      mem.mem_wreq   = 1'b0;

      case (state_reg)
         S_IDLE: begin
            if (ena) begin
               state_next = S_FETCH;
               cnt_next   = '0;
            end
         end
         S_FETCH: begin
            mem.mem_rreq = 1'b1;
            mem.mem_addr = pc_word;
            mem.mem_be   = '1;
            if (mem.mem_ack) begin
               instr_cap  = 1'b1;
               state_next = S_EXEC;
            end else if (timed_out) begin
               state_next = S_ABORT;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         S_EXEC: begin
            E = 1'b1;
            if (wren || rren) begin
               state_next = S_DATA;
               cnt_next   = '0;
            end else begin
               state_next = S_COMMIT;
            end
         end
         S_DATA: begin
            E = 1'b1;
            // A combined load/store request is executed as the store alone.
            if (wren) begin
               mem.mem_wreq  = 1'b1;
               mem.mem_addr  = data_addr;
               mem.mem_wdata = data_wdata;
               mem.mem_be    = data_be;
            end else if (rren) begin
               mem.mem_rreq = 1'b1;
               mem.mem_addr = data_addr;
               mem.mem_be   = '1;
            end
            if (mem.mem_ack) begin
               load_cap   = !wren && rren;
               state_next = S_COMMIT;
            end else if (timed_out) begin
               state_next = S_ABORT;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         S_COMMIT: begin
            E          = 1'b1;
            commit     = 1'b1;
            state_next = S_IDLE;
         end
         S_ABORT: begin
            abort = 1'b1;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase

      // Flush wins over any ack seen in the same cycle.
      if (jisr) begin
         state_next = S_IDLE;
         cnt_next   = '0;
         instr_cap  = 1'b0;
         load_cap   = 1'b0;
      end
   end

   assign busy      = (state_reg != S_IDLE);
   assign instr     = instr_reg;
   assign load_data = load_reg;

endmodule

// File: tb/tb_mem_phase_ctrl.sv
// Scoreboard bench for mem_phase_ctrl: scripted cycle-by-cycle stimulus pushes
// expected memory/commit/abort events; a negedge monitor pops and compares.
module tb_mem_phase_ctrl;

   localparam int ADDR_W  = 27;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 4;

   localparam logic [1:0] EV_RD = 2'd0;
   localparam logic [1:0] EV_WR = 2'd1;
   localparam logic [1:0] EV_COMMIT = 2'd2;
   localparam logic [1:0] EV_ABORT = 2'd3;

   typedef struct packed {
      logic [1:0]          kind;
      logic [ADDR_W-1:0]   addr;
      logic [DATA_W-1:0]   wdata;
      logic [3:0]          be;
      logic [DATA_W-1:0]   instr;
      logic [DATA_W-1:0]   ld;
   } ev_t;

   logic                clk = 1'b0;
   logic                rst;
   logic                ena;
   logic                jisr;
   logic [ADDR_W-1:0]   pc_word;
   logic [ADDR_W-1:0]   data_addr;
   logic [DATA_W-1:0]   data_wdata;
   logic [DATA_W/8-1:0] data_be;
   logic                rren;
   logic                wren;
   logic [DATA_W-1:0]   instr;
   logic [DATA_W-1:0]   load_data;
   logic                E;
   logic                commit;
   logic                abort;
   logic                busy;

   mem_phase_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

   mem_phase_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .jisr       (jisr),
      .pc_word    (pc_word),
      .data_addr  (data_addr),
      .data_wdata (data_wdata),
      .data_be    (data_be),
      .rren       (rren),
      .wren       (wren),
      .instr      (instr),
      .load_data  (load_data),
      .E          (E),
      .commit     (commit),
      .abort      (abort),
      .busy       (busy),
      .mem        (mem_if.master)
   );

   always #5 clk = ~clk;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_rreq  = 0;
   int   n_wreq  = 0;
   int   n_commit = 0;
   logic abort_prev = 1'b0;
   ev_t  exp_q[$];

   function automatic ev_t mk_ev(logic [1:0] kind, logic [ADDR_W-1:0] addr,
                                 logic [DATA_W-1:0] wdata, logic [3:0] be,
                                 logic [DATA_W-1:0] ins, logic [DATA_W-1:0] ld);
      ev_t e;
      e.kind  = kind;
      e.addr  = addr;
      e.wdata = wdata;
      e.be    = be;
      e.instr = ins;
      e.ld    = ld;
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic observe(input ev_t got);
      ev_t exp;
      n_tests++;
      $display("[TB] t=%0t event kind=%0d addr=%h wdata=%h be=%b instr=%h ld=%h",
               $time, got.kind, got.addr, got.wdata, got.be, got.instr, got.ld);
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("[TB] FAIL sb_unexpected: got kind=%0d addr=%h, expected no event",
                  got.kind, got.addr);
      end else begin
         exp = exp_q.pop_front();
         if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL sb_event: got kind=%0d addr=%h wdata=%h be=%b instr=%h ld=%h expected kind=%0d addr=%h wdata=%h be=%b instr=%h ld=%h",
                     got.kind, got.addr, got.wdata, got.be, got.instr, got.ld,
                     exp.kind, exp.addr, exp.wdata, exp.be, exp.instr, exp.ld);
         end
      end
   endtask

   // Monitor: samples mid-cycle, turns bus handshakes and strobes into events.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (mem_if.mem_rreq) n_rreq++;
         if (mem_if.mem_wreq) n_wreq++;
         if (commit) n_commit++;
         if (mem_if.mem_rreq || mem_if.mem_wreq) begin
            n_tests++;
            if (mem_if.mem_rreq && mem_if.mem_wreq) begin
               n_fail++;
               $display("[TB] FAIL req_exclusive: got rreq=1 wreq=1 expected at most one");
            end
         end
         if (mem_if.mem_rreq && mem_if.mem_ack && !jisr)
            observe(mk_ev(EV_RD, mem_if.mem_addr, '0, mem_if.mem_be, '0, '0));
         if (mem_if.mem_wreq && mem_if.mem_ack && !jisr)
            observe(mk_ev(EV_WR, mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_be, '0, '0));
         if (commit)
            observe(mk_ev(EV_COMMIT, '0, '0, '0, instr, load_data));
         if (abort && !abort_prev)
            observe(mk_ev(EV_ABORT, '0, '0, '0, '0, '0));
      end
      abort_prev = (rst === 1'b1) && (abort === 1'b1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0] e_tr;
      logic [4:0] c_tr;
      int         r0, w0, c0;

      rst = 1'b0; ena = 1'b1; jisr = 1'b0;
      pc_word = '0; data_addr = '0; data_wdata = '0; data_be = '0;
      rren = 1'b0; wren = 1'b0;
      mem_if.mem_ack = 1'b0; mem_if.mem_rdata = '0;

      // Reset held two cycles with ena high.
      step(); step();
      chk("rst_instr", 64'(instr), 64'h0);
      chk("rst_load", 64'(load_data), 64'h0);
      chk("rst_flags", 64'({E, commit, abort, busy, mem_if.mem_rreq, mem_if.mem_wreq}), 64'h0);
      chk("rst_bus", 64'({mem_if.mem_addr, mem_if.mem_be}), 64'h0);

      // Non-memory instruction, ack present from release.
      exp_q.push_back(mk_ev(EV_RD, 27'h10, '0, 4'hf, '0, '0));
      exp_q.push_back(mk_ev(EV_COMMIT, '0, '0, '0, 32'h2008_0005, 32'h0));
      rst = 1'b1; pc_word = 27'h10; mem_if.mem_rdata = 32'h2008_0005; mem_if.mem_ack = 1'b1;
      for (int c = 0; c < 5; c++) begin
         e_tr[c] = E;
         c_tr[c] = commit;
         step();
         if (c == 0) ena = 1'b0;
      end
      mem_if.mem_ack = 1'b0;
      chk("nomem_E_trace", 64'(e_tr), 64'b01100);
      chk("nomem_commit_trace", 64'(c_tr), 64'b01000);
      chk("nomem_instr", 64'(instr), 64'h2008_0005);

      // Load with ack on third DATA cycle.
      exp_q.push_back(mk_ev(EV_RD, 27'h11, '0, 4'hf, '0, '0));
      exp_q.push_back(mk_ev(EV_RD, 27'h40, '0, 4'hf, '0, '0));
      exp_q.push_back(mk_ev(EV_COMMIT, '0, '0, '0, 32'hA000_0011, 32'hDEAD_BEEF));
      r0 = n_rreq; c0 = n_commit;
      ena = 1'b1; pc_word = 27'h11; rren = 1'b1; data_addr = 27'h40;
      step();
      ena = 1'b0; mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'hA000_0011;
      step();
      mem_if.mem_ack = 1'b0;
      step(); step(); step();
      mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'hDEAD_BEEF;
      step();
      mem_if.mem_ack = 1'b0;
      step();
      rren = 1'b0;
      chk("load_rreq_cycles", 64'(n_rreq - r0), 64'd4);
      chk("load_commit_count", 64'(n_commit - c0), 64'd1);
      chk("load_data", 64'(load_data), 64'hDEAD_BEEF);

      // Store with both rren and wren set: write only.
      exp_q.push_back(mk_ev(EV_RD, 27'h12, '0, 4'hf, '0, '0));
      exp_q.push_back(mk_ev(EV_WR, 27'h44, 32'h1234_5678, 4'b0011, '0, '0));
      exp_q.push_back(mk_ev(EV_COMMIT, '0, '0, '0, 32'hA000_0012, 32'hDEAD_BEEF));
      r0 = n_rreq; w0 = n_wreq;
      ena = 1'b1; pc_word = 27'h12; rren = 1'b1; wren = 1'b1;
      data_addr = 27'h44; data_wdata = 32'h1234_5678; data_be = 4'b0011;
      step();
      ena = 1'b0; mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'hA000_0012;
      step();
      mem_if.mem_ack = 1'b0;
      step();
      mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'hBAD0_BAD0;
      step();
      mem_if.mem_ack = 1'b0;
      step();
      rren = 1'b0; wren = 1'b0;
      chk("store_rreq_cycles", 64'(n_rreq - r0), 64'd1);
      chk("store_wreq_cycles", 64'(n_wreq - w0), 64'd1);
      chk("store_load_kept", 64'(load_data), 64'hDEAD_BEEF);

      // Fetch timeout after TIMEOUT wait cycles.
      exp_q.push_back(mk_ev(EV_ABORT, '0, '0, '0, '0, '0));
      r0 = n_rreq; c0 = n_commit;
      ena = 1'b1; pc_word = 27'h13;
      step();
      ena = 1'b0;
      repeat (4) step();
      chk("abort_flags", 64'({abort, busy, E, mem_if.mem_rreq, mem_if.mem_wreq}), 64'b11000);
      mem_if.mem_ack = 1'b1;
      step(); step();
      mem_if.mem_ack = 1'b0;
      chk("abort_sticky", 64'({abort, busy}), 64'b11);
      chk("abort_rreq_cycles", 64'(n_rreq - r0), 64'd4);
      chk("abort_no_commit", 64'(n_commit - c0), 64'd0);

      // jisr leaves ABORT; fetch restarts with ena high.
      exp_q.push_back(mk_ev(EV_RD, 27'h14, '0, 4'hf, '0, '0));
      exp_q.push_back(mk_ev(EV_COMMIT, '0, '0, '0, 32'hA000_0014, 32'hDEAD_BEEF));
      ena = 1'b1; jisr = 1'b1; pc_word = 27'h14;
      step();
      jisr = 1'b0;
      chk("jisr_idle", 64'({abort, busy}), 64'b00);
      step();
      ena = 1'b0;
      chk("jisr_refetch", 64'({mem_if.mem_rreq, mem_if.mem_addr}), 64'({1'b1, 27'h14}));
      mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'hA000_0014;
      step();
      mem_if.mem_ack = 1'b0;
      step(); step();

      // Ack on the last allowed wait cycle is accepted.
      exp_q.push_back(mk_ev(EV_RD, 27'h15, '0, 4'hf, '0, '0));
      exp_q.push_back(mk_ev(EV_COMMIT, '0, '0, '0, 32'hA000_0015, 32'hDEAD_BEEF));
      ena = 1'b1; pc_word = 27'h15;
      step();
      ena = 1'b0;
      repeat (3) step();
      mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'hA000_0015;
      step();
      mem_if.mem_ack = 1'b0;
      chk("late_ack_exec", 64'({abort, E}), 64'b01);
      step(); step();

      // jisr coinciding with the DATA ack: no capture, no commit.
      exp_q.push_back(mk_ev(EV_RD, 27'h16, '0, 4'hf, '0, '0));
      c0 = n_commit;
      ena = 1'b1; pc_word = 27'h16; rren = 1'b1; data_addr = 27'h48;
      step();
      ena = 1'b0; mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'hA000_0016;
      step();
      mem_if.mem_ack = 1'b0;
      step();
      mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'h5555_5555; jisr = 1'b1;
      step();
      mem_if.mem_ack = 1'b0; jisr = 1'b0; rren = 1'b0;
      chk("jisr_ack_idle", 64'({busy, commit, E}), 64'b000);
      chk("jisr_ack_load_kept", 64'(load_data), 64'hDEAD_BEEF);
      chk("jisr_ack_instr", 64'(instr), 64'hA000_0016);
      step();
      chk("jisr_ack_no_commit", 64'(n_commit - c0), 64'd0);

      // Reset in the middle of DATA.
      exp_q.push_back(mk_ev(EV_RD, 27'h17, '0, 4'hf, '0, '0));
      ena = 1'b1; pc_word = 27'h17; rren = 1'b1; data_addr = 27'h4C;
      step();
      ena = 1'b0; mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'hA000_0017;
      step();
      mem_if.mem_ack = 1'b0;
      step(); step();
      rst = 1'b0;
      step();
      chk("midrst_regs", {instr, load_data}, 64'h0);
      chk("midrst_flags", 64'({E, commit, abort, busy, mem_if.mem_rreq, mem_if.mem_wreq}), 64'h0);
      chk("midrst_bus", 64'({mem_if.mem_addr, mem_if.mem_be}), 64'h0);
      rst = 1'b1; rren = 1'b0;
      step(); step();

      chk("sb_drain", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_phase_ctrl.md
Name: mem_phase_ctrl

Overview:
Parametrised fetch/execute phase sequencer that generates the CPU E phase and drives an external memory request/acknowledge port for instruction and data accesses. It has per-access timeout with sticky abort and a one-cycle commit strobe. It sits between the core (PC, decoder, GPR write enable) and the LPDDR2-side memory interface. It replaces the free-running E toggle with a handshake-driven sequence.

Parameters:
ADDR_W, 27, word address width on both core and memory sides
DATA_W, 32, data width; must be a multiple of 8
TIMEOUT, 255, maximum wait cycles for mem_ack per access (>=1)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  reset; synchronous, active-low
ena  input  1  run enable; sampled only in IDLE
jisr  input  1  synchronous flush to IDLE; clears abort
pc_word  input  ADDR_W  instruction word address
data_addr  input  ADDR_W  data word address (from ALU)
data_wdata  input  DATA_W  store data
data_be  input  DATA_W/8  store byte enables
rren  input  1  load request for current instruction
wren  input  1  store request for current instruction
instr  output  DATA_W  latched instruction
load_data  output  DATA_W  latched load data
E  output  1  execute phase
commit  output  1  one-cycle PC/GPR update strobe
abort  output  1  sticky timeout flag
busy  output  1  high whenever state != IDLE
mem_addr  output  ADDR_W  memory word address
mem_wdata  output  DATA_W  memory write data
mem_be  output  DATA_W/8  memory byte enables
mem_rreq  output  1  read request
mem_wreq  output  1  write request
mem_rdata  input  DATA_W  memory read data, valid with mem_ack
mem_ack  input  1  access complete

Behaviour:
- Reset (rst==0 at clk edge): state=IDLE, counter=0. All outputs 0, including instr and load_data. rst has priority over jisr.
- States: IDLE, FETCH, EXEC, DATA, COMMIT, ABORT. State is registered; outputs are decoded from state and inputs.
- IDLE: go to FETCH if ena==1, else stay.
- FETCH: mem_rreq=1, mem_addr=pc_word, mem_be=all ones.
  - If mem_ack==1: instr<=mem_rdata, go to EXEC.
- EXEC: E=1, no request. Go to DATA if wren or rren, else go to COMMIT.
- DATA:
  - If wren==1: mem_wreq=1, mem_addr=data_addr, mem_wdata=data_wdata, mem_be=data_be.
  - Else if rren==1: mem_rreq=1, mem_be=all ones.
  - wren has priority when both are set; the access is a write only.
  - On mem_ack: capture load_data<=mem_rdata for reads only, then go to COMMIT. load_data is unchanged on writes.
  - E=1 throughout DATA.
- COMMIT: E=1, commit=1 for exactly one cycle, then go to IDLE.
- Timeout:
  - counter is cleared on entry to FETCH and DATA and increments on each FETCH/DATA cycle without ack.
  - If counter==TIMEOUT-1 and mem_ack==0: go to ABORT. An ack on the TIMEOUT-th wait cycle is still accepted.
  - Counter width is clog2(TIMEOUT+1).
- ABORT: abort=1, all requests low, E=0. Exits only on rst==0 or jisr==1.
- jisr==1 in any state: next state IDLE, requests drop next cycle, abort cleared, counter cleared, instr/load_data retained.
  - An ack arriving in the same cycle as jisr is ignored; no capture, no commit.
- Request hold rule: a request, once raised, holds stable (addr, data, be) until the ack cycle. It deasserts the cycle after ack.
- Minimum latency:
  - Non-memory instruction: 4 cycles, IDLE→FETCH→EXEC→COMMIT, with ack in the first FETCH cycle.
  - Memory instruction: 5 cycles.
- mem_ack outside FETCH/DATA is ignored.
- ena dropping mid-instruction does not stop the sequence; it is checked only in IDLE.

Test Plan:
- Reset with rst=0 and ena=1 for 2 cycles -> all outputs 0, busy=0. Release rst, ack same cycle, pc_word=0x10, rdata=0x20080005, no rren/wren -> instr=0x20080005, commit high exactly at cycle 4, E high in cycles 3-4.
- Load: rren=1, data_addr=0x40, ack delayed 3 cycles with rdata=0xDEADBEEF -> mem_rreq held 3 cycles with addr 0x40, load_data=0xDEADBEEF, single commit pulse.
- Store with rren=wren=1, data_be=4'b0011, wdata=0x12345678 -> only mem_wreq asserts, mem_be=0011, load_data unchanged.
- TIMEOUT=4, no ack in FETCH -> abort=1 after 4 FETCH cycles, requests low, commit never asserts. Ack on 4th cycle instead -> no abort.
- In ABORT, pulse jisr -> IDLE next cycle, abort=0, fetch restarts if ena=1.
- jisr coinciding with mem_ack in DATA -> no load_data update, no commit, IDLE next cycle. rst low in the middle of DATA -> all outputs 0 next cycle.
